// File: rtl/spi_slave_pkg.sv
// Shared types for the oversampled SPI slave: FSM states, latched mode, counter sizing.
package spi_slave_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Bit counter must hold 0..width inclusive.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for one asynchronous pin, with optional rise/fall pulses
// taken from one extra flop behind the synchronised level.
module spi_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter bit          EDGE_EN = 1'b1,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

    generate
        if (EDGE_EN) begin : g_edge
            logic prev_q;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    prev_q <= RST_VAL;
                end else begin
                    prev_q <= q_o;
                end
            end

            assign rise_o = q_o & ~prev_q;
            assign fall_o = ~q_o & prev_q;
        end else begin : g_no_edge
            assign rise_o = 1'b0;
            assign fall_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/spi_slave_sync.sv
// Oversampled SPI slave: all SPI pins synchronised into CLK, all four CPOL/CPHA modes,
// buffered TX word with valid/ready. Optional FRAMEERR output via SPI_SLAVE_FRAME_ERR_EN.
module spi_slave_sync
    import spi_slave_pkg::*;
#(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SPICLK,
    input  logic             SPICS,
    input  logic             SHREGIN,
    output logic             SHREGOUT,
    input  logic             CPOL,
    input  logic             CPHA,
    input  logic [WIDTH-1:0] TXDATA,
    input  logic             TXVALID,
    output logic             TXREADY,
    output logic [WIDTH-1:0] RXDATA,
    output logic             RXVALID,
    output logic             TXUNDER,
    output logic             BUSY
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic             FRAMEERR
`endif
);

    localparam int unsigned      CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

    logic sclk_rise, sclk_fall, sclk_lvl_unused;
    logic cs_rise, cs_fall, cs_lvl_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1), .RST_VAL(1'b0)) u_sync_sclk (
        .clk_i  (CLK),
        .rst_i  (RST),
        .d_i    (SPICLK),
        .q_o    (sclk_lvl_unused),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1), .RST_VAL(1'b1)) u_sync_cs (
        .clk_i  (CLK),
        .rst_i  (RST),
        .d_i    (SPICS),
        .q_o    (cs_lvl_unused),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0), .RST_VAL(1'b0)) u_sync_mosi (
        .clk_i  (CLK),
        .rst_i  (RST),
        .d_i    (SHREGIN),
        .q_o    (mosi_s),
        .rise_o (mosi_rise_unused),
        .fall_o (mosi_fall_unused)
    );

    state_t           state_q;
    spi_mode_t        mode_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [WIDTH-1:0] tx_sh_q;
    logic [WIDTH-1:0] txbuf_q;
    logic             txfull_q;
    logic [WIDTH-1:0] rxdata_q;
    logic             rxvalid_q;
    logic             txunder_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic             frameerr_q;
`endif

    logic sample_ev, drive_ev, word_done, word_start, tx_load;

    assign sample_ev  = (mode_q.cpol == mode_q.cpha) ? sclk_rise : sclk_fall;
    assign drive_ev   = (mode_q.cpol == mode_q.cpha) ? sclk_fall : sclk_rise;
    assign word_done  = (state_q == ACTIVE) && !cs_rise && sample_ev && (cnt_q == LAST);
    assign word_start = ((state_q == IDLE) && cs_fall) || word_done;
    // A word-start transfer masks ready so a same-cycle load waits one cycle.
    assign TXREADY    = ~txfull_q & ~word_start;
    assign tx_load    = TXVALID & TXREADY;
    assign rx_sh_d    = {rx_sh_q[WIDTH-2:0], mosi_s};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            mode_q     <= '0;
            cnt_q      <= '0;
            rx_sh_q    <= '0;
            tx_sh_q    <= '0;
            txbuf_q    <= '0;
            txfull_q   <= 1'b0;
            rxdata_q   <= '0;
            rxvalid_q  <= 1'b0;
            txunder_q  <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frameerr_q <= 1'b0;
`endif
        end else begin
            rxvalid_q  <= 1'b0;
            txunder_q  <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frameerr_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q <= ACTIVE;
                        mode_q  <= '{cpol: CPOL, cpha: CPHA};
                        cnt_q   <= '0;
                        rx_sh_q <= '0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        rx_sh_q <= '0;
                        tx_sh_q <= '0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                        frameerr_q <= (cnt_q != '0);
`endif
                    end else if (sample_ev) begin
                        rx_sh_q <= rx_sh_d;
                        if (cnt_q == LAST) begin
                            rxdata_q  <= rx_sh_d;
                            rxvalid_q <= 1'b1;
                            cnt_q     <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else if (drive_ev && (cnt_q != '0)) begin
                        // Holding at count 0 keeps the first bit for CPHA=1 and the
                        // leading CPHA=0 bit alike.
                        tx_sh_q <= {tx_sh_q[WIDTH-2:0], 1'b0};
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (word_start) begin
                if (txfull_q) begin
                    tx_sh_q  <= txbuf_q;
                    txfull_q <= 1'b0;
                end else begin
                    tx_sh_q   <= '0;
                    txunder_q <= 1'b1;
                end
            end else if (tx_load) begin
                txbuf_q  <= TXDATA;
                txfull_q <= 1'b1;
            end
        end
    end

    assign SHREGOUT = tx_sh_q[WIDTH-1];
    assign RXDATA   = rxdata_q;
    assign RXVALID  = rxvalid_q;
    assign TXUNDER  = txunder_q;
    assign BUSY     = (state_q == ACTIVE);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    assign FRAMEERR = frameerr_q;
`endif

endmodule
